// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer slice.
//   - opcode codes understood by the external ALU
//   - OP_IDLE: code parked on alu_op after reset (an illegal op)
//   - sequencer state encoding
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SHL  = 4'd2;
  localparam logic [3:0] OP_SHR  = 4'd3;
  localparam logic [3:0] OP_EQ   = 4'd4;
  localparam logic [3:0] OP_LT   = 4'd5;
  localparam logic [3:0] OP_GT   = 4'd6;
  localparam logic [3:0] OP_IDLE = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_rsp_mask.sv
// Per-opcode result mask. Combinational.
// Ports:
//   op                         opcode the ALU is executing
//   alu_o/of_und/err/zero      raw ALU outputs
//   m_o/m_of_und/m_err/m_zero  masked fields; anything not meaningful for
//                              the opcode is forced to 0
module alu_rsp_mask
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_of_und,
  input  logic             alu_err,
  input  logic             alu_zero,
  output logic [WIDTH-1:0] m_o,
  output logic             m_of_und,
  output logic             m_err,
  output logic             m_zero
);

  always_comb begin
    m_o      = '0;
    m_of_und = 1'b0;
    m_err    = 1'b0;
    m_zero   = 1'b0;
    case (op)
      OP_ADD, OP_SUB: begin
        m_o      = alu_o;
        m_of_und = alu_of_und;
      end
      OP_SHL:              m_of_und = alu_of_und;
      OP_SHR:              m_o      = alu_o;
      OP_EQ, OP_LT, OP_GT: m_zero   = alu_zero;
      // Illegal opcodes always report an error, whatever the ALU says.
      default:             m_err    = 1'b1;
    endcase
  end

  // The ALU's own err flag is redundant given the opcode decode above.
  logic unused_err;
  assign unused_err = alu_err;

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator for a combinational ALU: takes tagged commands on a valid/ready
// stream, registers A/B/Op into the ALU, waits one settle cycle, captures
// the masked result and returns it with the tag on a valid/ready stream.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/ready, cmd_*    command stream (op, a, b, tag)
//   alu_a/b/op                registered operands/opcode to the ALU
//   alu_o/of_und/err/zero     ALU outputs
//   rsp_valid/ready, rsp_*    response stream (masked result + tag)
//   cmd_count, err_count      saturating status counters
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_o,
  input  logic             alu_of_und,
  input  logic             alu_err,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_o,
  output logic             rsp_of_und,
  output logic             rsp_err,
  output logic             rsp_zero,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [CNT_W-1:0] cmd_count,
  output logic [CNT_W-1:0] err_count
);

  state_t           state, state_nxt;
  logic             accept, capture;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] m_o;
  logic             m_of_und, m_err, m_zero;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_valid) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = cmd_valid ? EXEC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: in RESP a new command rides on the response handshake edge.
  always_comb begin
    cmd_ready = 1'b0;
    case (state)
      IDLE:    cmd_ready = 1'b1;
      RESP:    cmd_ready = rsp_ready;
      default: cmd_ready = 1'b0;
    endcase
    accept  = cmd_valid & cmd_ready;
    capture = (state == EXEC);
  end

  // The mask keys off the registered opcode, i.e. what the ALU is running.
  alu_rsp_mask #(.WIDTH(WIDTH)) u_mask (
    .op         (alu_op),
    .alu_o      (alu_o),
    .alu_of_und (alu_of_und),
    .alu_err    (alu_err),
    .alu_zero   (alu_zero),
    .m_o        (m_o),
    .m_of_und   (m_of_und),
    .m_err      (m_err),
    .m_zero     (m_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= OP_IDLE;
      tag_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_o      <= '0;
      rsp_of_und <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_zero   <= 1'b0;
      rsp_tag    <= '0;
      cmd_count  <= '0;
      err_count  <= '0;
    end else begin
      if (accept) begin
        alu_a  <= cmd_a;
        alu_b  <= cmd_b;
        alu_op <= cmd_op;
        tag_q  <= cmd_tag;
        if (cmd_count != '1) cmd_count <= cmd_count + CNT_W'(1);
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_o      <= m_o;
        rsp_of_und <= m_of_und;
        rsp_err    <= m_err;
        rsp_zero   <= m_zero;
        rsp_tag    <= tag_q;
        if (m_err && err_count != '1) err_count <= err_count + CNT_W'(1);
      end else if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
module tb_alu_cmd_sequencer;
  localparam int WIDTH = 8;
  localparam int TAG_W = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready;
  logic [3:0]       cmd_op;
  logic [WIDTH-1:0] cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic [WIDTH-1:0] alu_a, alu_b;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_o;
  logic             alu_of_und, alu_err, alu_zero;
  logic             rsp_valid, rsp_ready;
  logic [WIDTH-1:0] rsp_o;
  logic             rsp_of_und, rsp_err, rsp_zero;
  logic [TAG_W-1:0] rsp_tag;
  logic [CNT_W-1:0] cmd_count, err_count;

  alu_cmd_sequencer #(.WIDTH(WIDTH), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_o(alu_o), .alu_of_und(alu_of_und), .alu_err(alu_err), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_o(rsp_o),
    .rsp_of_und(rsp_of_und), .rsp_err(rsp_err), .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
    .cmd_count(cmd_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Behavioural ALU stand-in. Fields the mask should discard carry junk.
  always_comb begin
    logic [8:0]  w9;
    logic [15:0] w16;
    w9 = '0; w16 = '0;
    alu_o = '0; alu_of_und = 1'b0; alu_err = 1'b0; alu_zero = 1'b0;
    case (alu_op)
      4'd0: begin w9 = {1'b0, alu_a} + {1'b0, alu_b}; alu_o = w9[7:0]; alu_of_und = w9[8]; alu_zero = (w9[7:0] == 0); end
      4'd1: begin w9 = {1'b0, alu_a} - {1'b0, alu_b}; alu_o = w9[7:0]; alu_of_und = w9[8]; alu_zero = (w9[7:0] == 0); end
      4'd2: begin w16 = {8'b0, alu_a} << alu_b[2:0]; alu_o = w16[7:0]; alu_of_und = |w16[15:8]; alu_zero = 1'b1; end
      4'd3: begin alu_o = alu_a >> alu_b[2:0]; alu_of_und = 1'b1; alu_zero = 1'b1; end
      4'd4: begin alu_o = alu_a ^ alu_b; alu_of_und = 1'b1; alu_zero = (alu_a == alu_b); end
      4'd5: begin alu_o = alu_a ^ alu_b; alu_of_und = 1'b1; alu_zero = (alu_a < alu_b); end
      4'd6: begin alu_o = alu_a ^ alu_b; alu_of_und = 1'b1; alu_zero = (alu_a > alu_b); end
      default: begin alu_o = alu_a + alu_b; alu_of_und = 1'b1; alu_err = alu_op[0]; alu_zero = 1'b1; end
    endcase
  end

  typedef struct {
    logic [WIDTH-1:0] o;
    logic             of_und, err, zero;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  int   m_cmd = 0, m_err = 0;
  int   rr_mode = 0;   // 0: rsp_ready=1, 1: random, 2: held low

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Reference: the masked response written straight from the opcode rules.
  function automatic exp_t ref_rsp(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                   input logic [3:0] tag);
    exp_t e;
    int ai = a, bi = b, sh = b % 8;
    e.o = 0; e.of_und = 0; e.err = 0; e.zero = 0; e.tag = tag;
    case (op)
      0: begin e.o = 8'((ai + bi) % 256); e.of_und = (ai + bi) > 255; end
      1: begin e.o = 8'((ai - bi + 256) % 256); e.of_und = ai < bi; end
      2: e.of_und = (ai * (1 << sh)) > 255;
      3: e.o = 8'(ai / (1 << sh));
      4: e.zero = (ai == bi);
      5: e.zero = (ai < bi);
      6: e.zero = (ai > bi);
      default: e.err = 1;
    endcase
    return e;
  endfunction

  function automatic logic [31:0] pack(input exp_t e);
    return {15'b0, e.o, e.of_und, e.err, e.zero, e.tag};
  endfunction

  // rsp_ready only moves just after a rising edge.
  initial begin
    rsp_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rr_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(0, 1));
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every negedge with valid&ready is exactly one transfer.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (!rst && rsp_valid && rsp_ready) begin
        if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          a.o = rsp_o; a.of_und = rsp_of_und; a.err = rsp_err; a.zero = rsp_zero; a.tag = rsp_tag;
          chk("rsp{o,of,err,zero,tag}", pack(a), pack(e));
        end
      end
    end
  end

  // Caller sits at a negedge. Returns at the negedge of the RESP cycle,
  // unless rst_exec is set, in which case reset is pulsed during EXEC.
  task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [3:0] tag, input bit rst_exec);
    int n;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    for (n = 0; n < 50 && !cmd_ready; n++) @(negedge clk);
    if (!cmd_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    q.push_back(ref_rsp(op, a, b, tag));
    if (m_cmd < CMAX) m_cmd++;
    if (op > 6 && m_err < CMAX) m_err++;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_op = 4'($urandom); cmd_a = 8'($urandom); cmd_b = 8'($urandom); cmd_tag = 4'($urandom);
    @(negedge clk);
    chk("exec_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("exec_cmd_ready", {31'b0, cmd_ready}, 32'd0);
    chk("exec_alu_abop", {12'b0, alu_a, alu_b, alu_op}, {12'b0, a, b, op});
    if (rst_exec) begin
      rst = 1'b1;
      void'(q.pop_back());
      m_cmd = 0; m_err = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_alu_op", {28'b0, alu_op}, 32'hF);
      chk("rst_counts", {28'b0, cmd_count, err_count}, 32'd0);
      return;
    end
    @(negedge clk);
    chk("latency_rsp_valid", {31'b0, rsp_valid}, 32'd1);
  endtask

  task automatic chk_counts(input string name);
    chk(name, {28'b0, cmd_count, err_count}, {28'b0, 2'(m_cmd), 2'(m_err)});
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 4'd0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_alu", {12'b0, alu_a, alu_b, alu_op}, 32'h0000F);
    chk("reset_rsp", {19'b0, rsp_o, rsp_of_und, rsp_err, rsp_zero, rsp_tag}, 32'd0);
    chk("reset_counts", {28'b0, cmd_count, err_count}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Directed vectors
    send(4'd0, 8'd200, 8'd100, 4'd3, 0);
    chk_counts("count_after_add");
    chk("add_expect", pack(ref_rsp(4'd0, 8'd200, 8'd100, 4'd3)), {15'b0, 8'd44, 1'b1, 1'b0, 1'b0, 4'd3});
    send(4'd1, 8'd5, 8'd10, 4'd4, 0);
    send(4'd2, 8'h81, 8'd1, 4'd5, 0);
    send(4'd5, 8'd3, 8'd7, 4'd6, 0);
    send(4'd9, 8'd1, 8'd2, 4'd7, 0);
    send(4'd3, 8'hF0, 8'd4, 4'd8, 0);
    chk_counts("count_after_directed");

    // Backpressure: response held for 5 cycles, then same-edge accept.
    rr_mode = 2;
    @(negedge clk);
    send(4'd4, 8'd9, 8'd9, 4'hA, 0);
    e = ref_rsp(4'd4, 8'd9, 8'd9, 4'hA);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp_held", {12'b0, rsp_valid, rsp_o, rsp_of_und, rsp_err, rsp_zero, rsp_tag},
          {12'b0, 1'b1, e.o, e.of_und, e.err, e.zero, e.tag});
      chk("bp_cmd_ready", {31'b0, cmd_ready}, 32'd0);
      chk("bp_alu_held", {12'b0, alu_a, alu_b, alu_op}, {12'b0, 8'd9, 8'd9, 4'd4});
    end
    rr_mode = 0;
    send(4'd6, 8'd50, 8'd20, 4'hB, 0);

    // Reset during EXEC: command dropped, nothing emitted.
    send(4'd0, 8'd1, 8'd1, 4'hC, 1);
    repeat (6) @(negedge clk);
    chk("post_rst_no_rsp", {31'b0, rsp_valid}, 32'd0);

    // Saturation with five illegal ops.
    for (int i = 0; i < 5; i++) send(4'(7 + i), 8'(i), 8'(i), 4'(i), 0);
    chk_counts("saturated_counts");
    chk("saturated_raw", {28'b0, cmd_count, err_count}, 32'hF);

    // Randomized traffic with random backpressure.
    rr_mode = 1;
    for (int i = 0; i < 200; i++)
      send(4'($urandom_range(0, 15)), 8'($urandom), 8'($urandom), 4'($urandom), 0);

    rr_mode = 0;
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    chk("drain_empty", q.size(), 32'd0);
    chk_counts("final_counts");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
